// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan controller.
package mux_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Per-channel dwell timer: counts 0..DWELL-1 while run is high and
// pulses tick on the last count, giving the mux path time to settle.
module dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  // Terminal count decode; only meaningful while scanning.
  always_comb begin
    w_last = (r_cnt == LAST);
    tick   = run & w_last;
  end

  // Counter is held at zero outside a scan so each scan starts fresh.
  always_ff @(posedge clk) begin
    if (rst || !run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_4to1.sv
// Plain 4:1 mux; the scan controller drives s and samples y.
module mux_4to1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  // Pick the data bit addressed by the select lines.
  always_comb begin
    y = d[s];
  end

endmodule

// File: rtl/mux_scan_capture.sv
// Scan controller around mux_4to1: steps sel through the channels,
// samples mux_y once per channel and presents 4-bit frames on a
// single-entry valid/ready output with a sticky overrun flag.
module mux_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_y,
  output logic [N_CH-1:0]  frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  scan_state_t      r_state;
  logic [SEL_W-1:0] r_sel;
  logic [N_CH-1:0]  r_cap;
  logic [N_CH-1:0]  r_frame;
  logic             r_fv;
  logic             r_ovr;

  logic             w_run;
  logic             w_tick;
  logic [N_CH-1:0]  w_cap_next;

  assign w_run = (r_state == S_SCAN);

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .run  (w_run),
    .tick (w_tick)
  );

  // Capture register with the current sample merged in; on the last
  // channel this is the complete frame offered to the holding register.
  always_comb begin
    w_cap_next        = r_cap;
    w_cap_next[r_sel] = mux_y;
  end

  // Scan FSM, capture, holding register and overrun tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cap   <= '0;
      r_frame <= '0;
      r_fv    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // Clear first so a drop on the same edge overrides it.
      if (clr_overrun) begin
        r_ovr <= 1'b0;
      end
      if (r_fv && frame_ready) begin
        r_fv <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SCAN;
            r_sel   <= '0;
          end
        end
        S_SCAN: begin
          if (w_tick) begin
            r_cap <= w_cap_next;
            r_sel <= r_sel + SEL_W'(1);
            if (r_sel == LAST_CH) begin
              if (!r_fv || frame_ready) begin
                r_frame <= w_cap_next;
                r_fv    <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
              if (!cont) begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= '0;
        end
      endcase
    end
  end

  assign sel         = r_sel;
  assign frame       = r_frame;
  assign frame_valid = r_fv;
  assign busy        = w_run;
  assign overrun     = r_ovr;

endmodule
